// File: rtl/rtc_field_pkg.sv
// Shared definitions for the RTC field bank: field indices, PS/2 key codes,
// controller states and per-field BCD limits.
package rtc_field_pkg;

  localparam logic [3:0] F_HO     = 4'd0;
  localparam logic [3:0] F_MIN    = 4'd1;
  localparam logic [3:0] F_SEG    = 4'd2;
  localparam logic [3:0] F_MES    = 4'd3;
  localparam logic [3:0] F_DIA    = 4'd4;
  localparam logic [3:0] F_ANO    = 4'd5;
  localparam logic [3:0] F_HO_TI  = 4'd6;
  localparam logic [3:0] F_MIN_TI = 4'd7;
  localparam logic [3:0] F_SEG_TI = 4'd8;

  localparam logic [7:0] KEY_UP = 8'h75;
  localparam logic [7:0] KEY_DN = 8'h72;
  localparam logic [7:0] KEY_R  = 8'h74;
  localparam logic [7:0] KEY_L  = 8'h6b;

  typedef enum logic [1:0] {
    CAPTURE,
    EDIT,
    FLUSH
  } state_e;

  function automatic logic [7:0] field_min(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      F_MES, F_DIA: v = 8'h01;
      default:      v = 8'h00;
    endcase
    return v;
  endfunction

  // Indices beyond the nine named fields behave as plain 00..99 counters.
  function automatic logic [7:0] field_max(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      F_HO, F_HO_TI:                   v = 8'h23;
      F_MIN, F_SEG, F_MIN_TI, F_SEG_TI: v = 8'h59;
      F_MES:                           v = 8'h12;
      F_DIA:                           v = 8'h31;
      default:                         v = 8'h99;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rtc_field_bank_bcd_step.sv
// Two-digit BCD increment/decrement with wrap between min and max.
// Values outside the limits (or with a non-decimal digit) snap to min.
module bcd_step #(
  parameter int unsigned FW = 8
) (
  input  logic [FW-1:0] value_i,
  input  logic [FW-1:0] min_i,
  input  logic [FW-1:0] max_i,
  input  logic          up_i,
  input  logic          down_i,
  output logic [FW-1:0] next_o
);

  logic [3:0]    tens;
  logic [3:0]    units;
  logic          in_lim;
  logic [FW-1:0] inc_v;
  logic [FW-1:0] dec_v;

  assign tens   = value_i[7:4];
  assign units  = value_i[3:0];
  assign in_lim = (tens <= 4'd9) && (units <= 4'd9) &&
                  (value_i >= min_i) && (value_i <= max_i);

  always_comb begin
    inc_v = value_i;
    dec_v = value_i;
    if (units == 4'd9) begin
      inc_v[3:0] = 4'd0;
      inc_v[7:4] = tens + 4'd1;
    end else begin
      inc_v[3:0] = units + 4'd1;
    end
    if (units == 4'd0) begin
      dec_v[3:0] = 4'd9;
      dec_v[7:4] = tens - 4'd1;
    end else begin
      dec_v[3:0] = units - 4'd1;
    end
  end

  always_comb begin
    next_o = value_i;
    if (up_i) begin
      next_o = (!in_lim || (value_i == max_i)) ? min_i : inc_v;
    end else if (down_i) begin
      if (!in_lim)               next_o = min_i;
      else if (value_i == min_i) next_o = max_i;
      else                       next_o = dec_v;
    end
  end

endmodule

// File: rtl/rtc_field_bank.sv
// RTC display field bank: captures read-back fields, edits them from PS/2
// keys, and writes only the modified fields back over a valid/ready port.
module rtc_field_bank
  import rtc_field_pkg::*;
#(
  parameter int unsigned NUM_FIELDS = 9,
  parameter int unsigned FW         = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     escribiendo,
  input  logic                     en_out,
  input  logic [3:0]               direccion,
  input  logic [FW-1:0]            rd_data,
  input  logic                     key_valid,
  input  logic [7:0]               key_code,
  input  logic                     wr_ready,
  output logic                     wr_valid,
  output logic [3:0]               wr_addr,
  output logic [FW-1:0]            wr_data,
  output logic [NUM_FIELDS*FW-1:0] fields,
  output logic [3:0]               cursor,
  output logic                     editing,
  output logic                     busy
);

  localparam logic [4:0] NF   = 5'(NUM_FIELDS);
  localparam logic [3:0] LAST = 4'(NUM_FIELDS - 1);

  state_e                  state_q, state_d;
  logic [FW-1:0]           fields_q [NUM_FIELDS];
  logic [FW-1:0]           fields_d [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]   dirty_q, dirty_d;
  logic [3:0]              cursor_q, cursor_d;
  logic                    esc_q;
  logic [FW-1:0]           step_next;
  logic [3:0]              low_idx;

  bcd_step #(.FW(FW)) u_step (
    .value_i (fields_q[cursor_q]),
    .min_i   (FW'(field_min(cursor_q))),
    .max_i   (FW'(field_max(cursor_q))),
    .up_i    (key_code == KEY_UP),
    .down_i  (key_code == KEY_DN),
    .next_o  (step_next)
  );

  // Scan from the top so the last hit is the lowest dirty index.
  always_comb begin
    low_idx = '0;
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      if (dirty_q[NUM_FIELDS-1-i]) low_idx = 4'(NUM_FIELDS - 1 - i);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
      fields[i*FW +: FW] = fields_q[i];
    end
  end

  assign wr_valid = (state_q == FLUSH) && (|dirty_q);
  assign wr_addr  = low_idx;
  assign wr_data  = fields_q[low_idx];
  assign cursor   = cursor_q;
  assign editing  = (state_q == EDIT);
  assign busy     = (state_q == FLUSH);

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    dirty_d  = dirty_q;
    fields_d = fields_q;
    case (state_q)
      CAPTURE: begin
        if (en_out && ({1'b0, direccion} < NF)) fields_d[direccion] = rd_data;
        if (escribiendo && !esc_q) begin
          state_d  = EDIT;
          cursor_d = '0;
          dirty_d  = '0;
        end
      end
      EDIT: begin
        if (key_valid) begin
          case (key_code)
            KEY_UP, KEY_DN: begin
              fields_d[cursor_q] = step_next;
              dirty_d[cursor_q]  = 1'b1;
            end
            KEY_R:   cursor_d = (cursor_q == LAST) ? '0 : cursor_q + 4'd1;
            KEY_L:   cursor_d = (cursor_q == '0) ? LAST : cursor_q - 4'd1;
            default: ;
          endcase
        end
        // A key on the falling edge of escribiendo still counts toward dirty.
        if (!escribiendo) state_d = (|dirty_d) ? FLUSH : CAPTURE;
      end
      FLUSH: begin
        if (wr_valid && wr_ready) dirty_d[low_idx] = 1'b0;
        if (dirty_d == '0) begin
          if (escribiendo) begin
            state_d  = EDIT;
            cursor_d = '0;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CAPTURE;
      cursor_q <= '0;
      dirty_q  <= '0;
      esc_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_FIELDS; i++) begin
        fields_q[i] <= FW'(field_min(4'(i)));
      end
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      dirty_q  <= dirty_d;
      esc_q    <= escribiendo;
      fields_q <= fields_d;
    end
  end

endmodule

// File: tb/tb_rtc_field_bank.sv
// Bench for rtc_field_bank: directed edit/flush scenarios plus random traffic
// compared every cycle against a decimal-arithmetic model of the field bank.
module tb_rtc_field_bank;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         escribiendo = 1'b0;
  logic         en_out = 1'b0;
  logic [3:0]   direccion = '0;
  logic [7:0]   rd_data = '0;
  logic         key_valid = 1'b0;
  logic [7:0]   key_code = '0;
  logic         wr_ready = 1'b0;
  logic         wr_valid;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic [N*8-1:0] fields;
  logic [3:0]   cursor;
  logic         editing;
  logic         busy;

  always #5 clk = ~clk;

  rtc_field_bank #(.NUM_FIELDS(N), .FW(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .escribiendo (escribiendo),
    .en_out      (en_out),
    .direccion   (direccion),
    .rd_data     (rd_data),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .wr_ready    (wr_ready),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .fields      (fields),
    .cursor      (cursor),
    .editing     (editing),
    .busy        (busy)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Model: limits in plain decimal; state 0=capture 1=edit 2=flush.
  int         mn [N] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};
  int         mx [N] = '{23, 59, 59, 12, 31, 99, 23, 59, 59};
  logic [7:0] mf [N];
  bit         md [N];
  int         mcur;
  int         mst;
  bit         mprev;

  function automatic logic [7:0] d2b(input int d);
    return 8'(((d / 10) << 4) | (d % 10));
  endfunction

  function automatic logic [7:0] m_step(input int idx, input logic [7:0] v, input bit up);
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (v[7:4] > 9 || v[3:0] > 9 || d < mn[idx] || d > mx[idx]) return d2b(mn[idx]);
    if (up) return d2b((d == mx[idx]) ? mn[idx] : d + 1);
    return d2b((d == mn[idx]) ? mx[idx] : d - 1);
  endfunction

  function automatic int lowest();
    for (int i = 0; i < N; i++) if (md[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mf[i] = d2b(mn[i]);
        md[i] = 1'b0;
      end
      mcur  = 0;
      mst   = 0;
      mprev = 1'b0;
    end else begin
      case (mst)
        0: begin
          if (en_out && int'(direccion) < N) mf[direccion] = rd_data;
          if (escribiendo && !mprev) begin
            mst  = 1;
            mcur = 0;
            for (int i = 0; i < N; i++) md[i] = 1'b0;
          end
        end
        1: begin
          if (key_valid) begin
            if (key_code == 8'h75) begin
              mf[mcur] = m_step(mcur, mf[mcur], 1'b1);
              md[mcur] = 1'b1;
            end else if (key_code == 8'h72) begin
              mf[mcur] = m_step(mcur, mf[mcur], 1'b0);
              md[mcur] = 1'b1;
            end else if (key_code == 8'h74) begin
              mcur = (mcur + 1) % N;
            end else if (key_code == 8'h6b) begin
              mcur = (mcur + N - 1) % N;
            end
          end
          if (!escribiendo) mst = (lowest() >= 0) ? 2 : 0;
        end
        default: begin
          if (wr_ready && lowest() >= 0) md[lowest()] = 1'b0;
          if (lowest() < 0) begin
            if (escribiendo) begin
              mst  = 1;
              mcur = 0;
            end else begin
              mst = 0;
            end
          end
        end
      endcase
      mprev = escribiendo;
    end
  end

  bit          cmp_en = 1'b0;
  logic [71:0] ef;
  bit          ev;

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) ef[i*8 +: 8] = mf[i];
      ev = (mst == 2) && (lowest() >= 0);
      chk("fields", fields, ef);
      chk("cursor", cursor, 72'(mcur));
      chk("editing", editing, 72'(mst == 1));
      chk("busy", busy, 72'(mst == 2));
      chk("wr_valid", wr_valid, 72'(ev));
      if (ev) begin
        chk("wr_addr", wr_addr, 72'(lowest()));
        chk("wr_data", wr_data, mf[lowest()]);
      end else if (!reset_n) begin
        chk("rst_wr_addr", wr_addr, 72'(0));
        chk("rst_wr_data", wr_data, d2b(mn[0]));
      end
    end
  end

  function automatic logic [7:0] fld(input int i);
    return fields[i*8 +: 8];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
    en_out    = 1'b0;
    key_valid = 1'b0;
  endtask

  task automatic cap(input logic [3:0] d, input logic [7:0] v);
    en_out    = 1'b1;
    direccion = d;
    rd_data   = v;
    cyc();
  endtask

  task automatic key(input logic [7:0] k);
    key_valid = 1'b1;
    key_code  = k;
    cyc();
  endtask

  logic [N*8-1:0] saved;

  initial begin
    reset_n = 1'b0;
    cmp_en  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_f0", fld(0), 8'h00);
    chk("rst_f3", fld(3), 8'h01);
    chk("rst_valid", wr_valid, 1'b0);
    chk("rst_cursor", cursor, 4'd0);
    reset_n = 1'b1;
    cyc();

    cap(4'd2, 8'h47);
    chk("cap_f2", fld(2), 8'h47);
    cap(4'd0, 8'h23);
    cap(4'd3, 8'h01);
    cap(4'd1, 8'h09);
    saved = fields;
    cap(4'hF, 8'h55);
    chk("cap_oob", fields, saved);

    escribiendo = 1'b1;
    cyc();
    chk("edit_enter", editing, 1'b1);
    chk("edit_cursor0", cursor, 4'd0);
    key(8'h75);
    chk("up_wrap_hours", fld(0), 8'h00);
    key(8'h72);
    chk("dn_wrap_hours", fld(0), 8'h23);
    repeat (3) key(8'h74);
    key(8'h72);
    chk("dn_wrap_month", fld(3), 8'h12);
    repeat (2) key(8'h6b);
    key(8'h75);
    chk("up_carry_min", fld(1), 8'h10);
    key(8'h6b);
    chk("cursor_l", cursor, 4'd0);
    key(8'h6b);
    chk("cursor_l_wrap", cursor, 4'd8);
    key(8'h74);
    chk("cursor_r_wrap", cursor, 4'd0);
    key(8'h1c);
    chk("cursor_other", cursor, 4'd0);

    escribiendo = 1'b0;
    wr_ready    = 1'b1;
    cyc();
    chk("flush1_busy", busy, 1'b1);
    for (int k = 0; k < 20 && busy; k++) cyc();
    chk("flush1_done", busy, 1'b0);
    wr_ready = 1'b0;

    escribiendo = 1'b1;
    cyc();
    key(8'h74);
    key(8'h75);
    repeat (4) key(8'h74);
    key(8'h75);
    escribiendo = 1'b0;
    cyc();
    repeat (3) begin
      chk("hold_valid", wr_valid, 1'b1);
      chk("hold_addr", wr_addr, 4'd1);
      chk("hold_data", wr_data, 8'h11);
      cyc();
    end
    wr_ready = 1'b1;
    chk("beat1_addr", wr_addr, 4'd1);
    cyc();
    chk("beat2_valid", wr_valid, 1'b1);
    chk("beat2_addr", wr_addr, 4'd5);
    chk("beat2_data", wr_data, 8'h01);
    cyc();
    chk("flush2_busy", busy, 1'b0);
    chk("flush2_valid", wr_valid, 1'b0);
    wr_ready = 1'b0;

    escribiendo = 1'b1;
    cyc();
    chk("noedit_enter", editing, 1'b1);
    escribiendo = 1'b0;
    cyc();
    chk("noedit_editing", editing, 1'b0);
    chk("noedit_busy", busy, 1'b0);
    chk("noedit_valid", wr_valid, 1'b0);

    escribiendo = 1'b1;
    cyc();
    repeat (2) key(8'h74);
    key(8'h75);
    chk("sec_up", fld(2), 8'h48);
    escribiendo = 1'b0;
    cyc();
    chk("rflush_busy", busy, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("rflush_valid", wr_valid, 1'b0);
    chk("rflush_f2", fld(2), 8'h00);
    @(posedge clk);
    #2 reset_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 29) == 0) escribiendo = ~escribiendo;
      en_out    = ($urandom_range(0, 3) == 0);
      direccion = 4'($urandom_range(0, 15));
      rd_data   = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      key_valid = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0:       key_code = 8'h75;
        1:       key_code = 8'h72;
        2:       key_code = 8'h74;
        3:       key_code = 8'h6b;
        4:       key_code = 8'h1c;
        default: key_code = 8'($urandom);
      endcase
      wr_ready = ($urandom_range(0, 2) != 0);
      if (c == 1500) reset_n = 1'b0;
      if (c == 1502) reset_n = 1'b1;
      @(posedge clk);
      #2;
    end

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
